aes_enc_iter: RTL and testbench

- Iterative AES forward-cipher datapath: one round per clock, sharing a single round-function datapath across all rounds.
- Encryption counterpart of the decryption round pipeline; sits beside it in the AES top.
- Round keys come from an external key-schedule store, addressed by a round index this block drives.
- Block interface is a valid/ready handshake in and a one-cycle valid pulse out.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_enc_iter.sv | 115 +++++++++++
 tb/tb_aes_enc_iter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block/round constants, round-engine FSM encoding and
// the GF(2^8) helpers (xtime, forward MixColumns on one column) that the
// decryption side builds its inverse functions on.
package aes_pkg;

  localparam int BLK_W  = 128;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam int RIDX_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ROUND = 1'b1
  } enc_state_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the [2 3 1 1] circulant; row 0 sits in [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES forward cipher: one round per clock through a single shared
// round datapath. Round keys are fetched from an external store addressed by
// oRoundIdx. Optional abort input enabled by defining AES_ENC_ABORT_EN.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic              clk,
  input  logic              rst,
`ifdef AES_ENC_ABORT_EN
  input  logic              iAbort,
`endif
  input  logic              iValid,
  output logic              oReady,
  input  logic [BLK_W-1:0]  iBlockIn,
  output logic [RIDX_W-1:0] oRoundIdx,
  input  logic [BLK_W-1:0]  iKeyValue,
  output logic              oValid,
  output logic [BLK_W-1:0]  oBlockout
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_enc_iter: NR must be 10, 12 or 14");
  end

  localparam logic [RIDX_W-1:0] NR_IDX = RIDX_W'(NR);

  enc_state_e        fsm_q, fsm_d;
  logic [BLK_W-1:0]  state_q, state_d;
  logic [RIDX_W-1:0] rnd_q, rnd_d;
  logic [BLK_W-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic              abort_w;

  logic [BLK_W-1:0]  sb_w;   // SubBytes(state)
  logic [BLK_W-1:0]  sr_w;   // ShiftRows(SubBytes(state))
  logic [BLK_W-1:0]  mc_w;   // MixColumns(ShiftRows(SubBytes(state)))

`ifdef AES_ENC_ABORT_EN
  assign abort_w = iAbort;
`else
  assign abort_w = 1'b0;
`endif

  // Byte gi of the block lives at row gi%4, column gi/4. ShiftRows rotates
  // row r left by r columns, so output byte (r,c) comes from (r,(c+r)%4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
    aes_sbox u_sbox (
      .byte_i(state_q[BLK_W-1-8*gi -: 8]),
      .byte_o(sb_w[BLK_W-1-8*gi -: 8])
    );
    assign sr_w[BLK_W-1-8*gi -: 8] = sb_w[BLK_W-1-8*SRC -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign mc_w[BLK_W-1-32*gi -: 32] = mix_column(sr_w[BLK_W-1-32*gi -: 32]);
  end

  assign oReady    = (fsm_q == ST_IDLE);
  assign oRoundIdx = rnd_q;
  assign oValid    = valid_q;
  assign oBlockout = out_q;

  // Next-state: accept + initial AddRoundKey in IDLE, one round per cycle in
  // ROUND; the final round skips MixColumns and publishes the ciphertext.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (fsm_q == ST_IDLE) begin
      if (iValid) begin
        state_d = iBlockIn ^ iKeyValue;
        rnd_d   = RIDX_W'(1);
        fsm_d   = ST_ROUND;
      end
    end else begin
      if (abort_w) begin
        rnd_d = '0;
        fsm_d = ST_IDLE;
      end else if (rnd_q == NR_IDX) begin
        out_d   = sr_w ^ iKeyValue;
        valid_d = 1'b1;
        rnd_d   = '0;
        fsm_d   = ST_IDLE;
      end else begin
        state_d = mc_w ^ iKeyValue;
        rnd_d   = rnd_q + RIDX_W'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: one NR=10 and one NR=14 instance,
// a byte-array AES reference model with its own key expansion and an S-box
// derived from GF(2^8) inversion plus the affine map.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel_b;
  logic         t_valid, t_abort;
  logic [127:0] t_blk;

  logic         a_valid, a_ready, a_ovalid;
  logic [3:0]   a_idx;
  logic [127:0] a_key, a_out;
  logic         b_valid, b_ready, b_ovalid;
  logic [3:0]   b_idx;
  logic [127:0] b_key, b_out;
  logic         m_ready, m_ovalid;
  logic [3:0]   m_idx;
  logic [127:0] m_out;

  logic [127:0] t_rk_nxt [0:15];
  logic [127:0] a_rk_cur [0:15];
  logic [127:0] b_rk_cur [0:15];
  logic [127:0] rk_tmp   [0:15];
  logic [7:0]   sb       [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign a_valid  = !sel_b && t_valid;
  assign b_valid  = sel_b && t_valid;
  assign m_ready  = sel_b ? b_ready  : a_ready;
  assign m_ovalid = sel_b ? b_ovalid : a_ovalid;
  assign m_idx    = sel_b ? b_idx    : a_idx;
  assign m_out    = sel_b ? b_out    : a_out;

  // Key store: the pending block's key set while idle, the in-flight set otherwise.
  assign a_key = a_ready ? t_rk_nxt[0] : a_rk_cur[a_idx];
  assign b_key = b_ready ? t_rk_nxt[0] : b_rk_cur[b_idx];

  always @(posedge clk) begin
    if (a_valid && a_ready) a_rk_cur <= t_rk_nxt;
    if (b_valid && b_ready) b_rk_cur <= t_rk_nxt;
  end

`ifdef AES_ENC_ABORT_EN
  logic a_abort, b_abort;
  assign a_abort = !sel_b && t_abort;
  assign b_abort = sel_b && t_abort;
`endif

  aes_enc_iter u_dut (
    .clk(clk), .rst(rst),
`ifdef AES_ENC_ABORT_EN
    .iAbort(a_abort),
`endif
    .iValid(a_valid), .oReady(a_ready), .iBlockIn(t_blk), .oRoundIdx(a_idx),
    .iKeyValue(a_key), .oValid(a_ovalid), .oBlockout(a_out)
  );

  aes_enc_iter #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst),
`ifdef AES_ENC_ABORT_EN
    .iAbort(b_abort),
`endif
    .iValid(b_valid), .oReady(b_ready), .iBlockIn(t_blk), .oRoundIdx(b_idx),
    .iKeyValue(b_key), .oValid(b_ovalid), .oBlockout(b_out)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key expansion into rk_tmp; key is left-aligned in 256 bits.
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tmp[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row + 4*col] = u[row + 4*((col + row) % 4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk_tmp[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_rst_values(input string tag);
    check_eq({tag, "_ready"}, 128'(a_ready), 128'(1));
    check_eq({tag, "_valid"}, 128'(a_ovalid), 128'(0));
    check_eq({tag, "_out"}, a_out, 128'(0));
    check_eq({tag, "_idx"}, 128'(a_idx), 128'(0));
  endtask

  // One full block on the selected instance, checked cycle by cycle.
  // Called and returns at a negedge.
  task automatic run_blk(input logic [127:0] pt, input logic [255:0] key, input int nk,
                         input logic [127:0] exp_in, input bit use_model, input bit noisy,
                         input string tag);
    int nr = nk + 6;
    logic [127:0] exp;
    expand(key, nk);
    exp = use_model ? ref_enc(pt, nr) : exp_in;
    t_rk_nxt = rk_tmp;
    t_blk   = pt;
    t_valid = 1'b1;
    check_eq($sformatf("%s_idle", tag), 128'({m_ready, m_idx}), 128'({1'b1, 4'd0}));
    @(negedge clk);
    t_valid = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      check_eq($sformatf("%s_r%0d", tag, k), 128'({m_ready, m_ovalid, m_idx}),
               128'({1'b0, 1'b0, 4'(k)}));
      if (noisy && k < nr) begin
        t_valid = 1'($urandom_range(0, 1));
        t_blk   = rnd128();
      end else begin
        t_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_eq($sformatf("%s_done", tag), 128'({m_ready, m_ovalid, m_idx}), 128'({1'b1, 1'b1, 4'd0}));
    check_eq($sformatf("%s_ct", tag), m_out, exp);
    @(negedge clk);
    check_eq($sformatf("%s_pulse", tag), 128'(m_ovalid), 128'(0));
    check_eq($sformatf("%s_hold", tag), m_out, exp);
  endtask

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int npulse, cyc1, cyc2, hits;
    logic [127:0] got1, got2;

    rst = 1'b1; sel_b = 1'b0; t_valid = 1'b0; t_abort = 1'b0; t_blk = '0;
    for (int i = 0; i < 16; i++) begin
      t_rk_nxt[i] = '0; a_rk_cur[i] = '0; b_rk_cur[i] = '0; rk_tmp[i] = '0;
    end
    build_sbox();

    // Reset asserted mid-cycle takes effect before any edge.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #2 rst = 1'b1; #1 check_rst_values("rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_blk(PT_C1, {KEY_C1, 128'h0}, 4, CT_C1, 1'b0, 1'b0, "c1");

    // Back-to-back with iValid held high.
    expand({KEY_B, 128'h0}, 4); t_rk_nxt = rk_tmp;
    t_blk = PT_B; t_valid = 1'b1;
    @(negedge clk);
    expand({KEY_C1, 128'h0}, 4); t_rk_nxt = rk_tmp;
    t_blk = PT_C1;
    npulse = 0; cyc1 = 0; cyc2 = 0; got1 = '0; got2 = '0;
    for (int i = 1; i <= 40 && npulse < 2; i++) begin
      @(negedge clk);
      if (a_ovalid) begin
        npulse++;
        if (npulse == 1) begin cyc1 = i; got1 = a_out; end
        else begin cyc2 = i; got2 = a_out; end
      end
      if (npulse == 1 && !a_ready) t_valid = 1'b0;
    end
    t_valid = 1'b0;
    check_eq("b2b_npulse", 128'(npulse), 128'(2));
    check_eq("b2b_ct1", got1, CT_B);
    check_eq("b2b_ct2", got2, CT_C1);
    check_eq("b2b_lat", 128'(cyc1), 128'(10));
    check_eq("b2b_gap", 128'(cyc2 - cyc1), 128'(11));
    @(negedge clk);
    check_eq("b2b_tail", 128'(a_ovalid), 128'(0));

    // Busy robustness: junk on iValid/iBlockIn during rounds.
    run_blk(PT_C1, {KEY_C1, 128'h0}, 4, CT_C1, 1'b0, 1'b1, "busy");

    // Reset at round 5.
    expand({KEY_C1, 128'h0}, 4); t_rk_nxt = rk_tmp;
    t_blk = PT_C1; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 12 && a_idx != 4'd5; i++) @(negedge clk);
    check_eq("rst5_reach", 128'(a_idx), 128'(5));
    #2 rst = 1'b1;
    #1 check_rst_values("rst5");
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (a_ovalid) hits++;
    end
    check_eq("rst5_novalid", 128'(hits), 128'(0));
    run_blk(PT_C1, {KEY_C1, 128'h0}, 4, CT_C1, 1'b0, 1'b0, "c1_rerun");

    // Random blocks against the model.
    for (int n = 0; n < 6; n++)
      run_blk(rnd128(), {rnd128(), 128'h0}, 4, '0, 1'b1, n[0], $sformatf("rnd%0d", n));

    // NR=14 instance.
    sel_b = 1'b1;
    @(negedge clk);
    run_blk(PT_C1, KEY_C3, 8, CT_C3, 1'b0, 1'b0, "c3");
    for (int n = 0; n < 2; n++)
      run_blk(rnd128(), {rnd128(), rnd128()}, 8, '0, 1'b1, 1'b0, $sformatf("rnd256_%0d", n));
    run_blk(PT_C1, KEY_C3, 8, CT_C3, 1'b0, 1'b0, "c3b");

`ifdef AES_ENC_ABORT_EN
    // Abort at round 7 on the NR=14 instance.
    expand(KEY_C3, 8); t_rk_nxt = rk_tmp;
    t_blk = PT_C1; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    for (int i = 0; i < 16 && b_idx != 4'd7; i++) @(negedge clk);
    check_eq("abort_reach", 128'(b_idx), 128'(7));
    t_abort = 1'b1;
    @(negedge clk);
    t_abort = 1'b0;
    check_eq("abort_state", 128'({b_ready, b_ovalid, b_idx}), 128'({1'b1, 1'b0, 4'd0}));
    check_eq("abort_out", b_out, CT_C3);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_ovalid) hits++;
    end
    check_eq("abort_novalid", 128'(hits), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
